// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter with a valid/ready input
// handshake and registered framing strobes. Back-to-back words leave no idle
// cycle, because a new word is accepted on the edge that ends the last bit.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             last_bit;
    logic             xfer;
    logic             sout_n, valid_n, start_n, end_n;

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign in_ready = !rst && ((state == IDLE) || last_bit);
    assign xfer     = in_valid && in_ready;
    assign busy     = sout_valid;

    // Next state, shift register and counter, plus the output values the next
    // cycle will show, so that every output comes straight from a flop.
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        if (xfer) begin
            sr_n    = in_data;
            cnt_n   = '0;
            state_n = SHIFT;
        end else if (state == SHIFT) begin
            sr_n = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
            if (last_bit) begin
                cnt_n   = '0;
                state_n = IDLE;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end

        valid_n = (state_n == SHIFT);
        sout_n  = valid_n && (MSB_FIRST ? sr_n[WIDTH-1] : sr_n[0]);
        start_n = valid_n && (cnt_n == '0);
        end_n   = valid_n && (cnt_n == LAST);
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            cnt         <= cnt_n;
            sout        <= sout_n;
            sout_valid  <= valid_n;
            frame_start <= start_n;
            frame_end   <= end_n;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives an MSB-first and an LSB-first serializer with the
// same inputs; each accepted word pushes its expected bit/framing sequence
// into a per-lane queue that is popped and compared every cycle.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;

    logic m_ready, m_sout, m_valid, m_start, m_end, m_busy;
    logic l_ready, l_sout, l_valid, l_start, l_end, l_busy;

    int checks   = 0;
    int failures = 0;

    logic [2:0] q_msb[$];
    logic [2:0] q_lsb[$];
    bit         last_xfer;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_ready),
        .in_data(in_data), .sout(m_sout), .sout_valid(m_valid),
        .frame_start(m_start), .frame_end(m_end), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_ready),
        .in_data(in_data), .sout(l_sout), .sout_valid(l_valid),
        .frame_start(l_start), .frame_end(l_end), .busy(l_busy)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Compares one lane's outputs against a popped entry {sout,start,end}, or
    // against all-zero when nothing is expected this cycle.
    task automatic checkLane(input string name, input bit have, input logic [2:0] exp,
                             input logic s, input logic v, input logic fs,
                             input logic fe, input logic b);
        checkOutput({name, "_sout"}, 32'(s), have ? 32'(exp[2]) : 32'd0);
        checkOutput({name, "_sout_valid"}, 32'(v), have ? 32'd1 : 32'd0);
        checkOutput({name, "_frame_start"}, 32'(fs), have ? 32'(exp[1]) : 32'd0);
        checkOutput({name, "_frame_end"}, 32'(fe), have ? 32'(exp[0]) : 32'd0);
        checkOutput({name, "_busy"}, 32'(b), have ? 32'd1 : 32'd0);
    endtask

    // One clock: model the handshake at the rising edge, check at the falling edge.
    task automatic tick();
        bit         ready;
        bit         have;
        logic [2:0] em;
        logic [2:0] el;
        @(posedge clk);
        ready     = !rst && (q_msb.size() == 0);
        last_xfer = ready && in_valid;
        if (rst) begin
            q_msb.delete();
            q_lsb.delete();
        end else if (last_xfer) begin
            for (int i = 0; i < W; i++) begin
                q_msb.push_back({in_data[W-1-i], i == 0, i == W - 1});
                q_lsb.push_back({in_data[i], i == 0, i == W - 1});
            end
        end
        @(negedge clk);
        have = (q_msb.size() != 0);
        em   = 3'b000;
        el   = 3'b000;
        if (have) begin
            em = q_msb.pop_front();
            el = q_lsb.pop_front();
        end
        checkLane("msb", have, em, m_sout, m_valid, m_start, m_end, m_busy);
        checkLane("lsb", have, el, l_sout, l_valid, l_start, l_end, l_busy);
        checkOutput("msb_in_ready", 32'(m_ready), 32'(!rst && q_msb.size() == 0));
        checkOutput("lsb_in_ready", 32'(l_ready), 32'(!rst && q_lsb.size() == 0));
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d);
        rst      = r;
        in_valid = v;
        in_data  = d;
        tick();
    endtask

    // Holds a word on the input until the model sees it accepted.
    task automatic sendWord(input logic [W-1:0] d);
        last_xfer = 1'b0;
        for (int n = 0; n < 40 && !last_xfer; n++) applyStimulus(1'b0, 1'b1, d);
        if (!last_xfer) checkOutput("xfer_timeout", 32'd0, 32'd1);
    endtask

    // Idles with random data on the bus until the expected stream is empty,
    // then one more cycle to confirm the outputs returned to zero.
    task automatic drain();
        for (int n = 0; n < 40 && q_msb.size() != 0; n++)
            applyStimulus(1'b0, 1'b0, W'($urandom));
        applyStimulus(1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
        $display("[TB] start");
        // Reset held with a pending handshake, then first transfer straight after.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        drain();

        // Single words.
        sendWord(8'hA5);
        drain();
        sendWord(8'h01);
        drain();

        // Back-to-back words with valid held high.
        sendWord(8'hA5);
        sendWord(8'h3C);
        drain();

        // Backpressure: second word offered early, accepted on the last bit.
        sendWord(8'hF0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        sendWord(8'h0F);
        drain();

        // Reset in the middle of a word, with a handshake on the reset edge.
        sendWord(8'hFF);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h81);
        sendWord(8'h81);
        drain();

        checkOutput("scoreboard_empty", 32'(q_msb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
